// File: rtl/reg_move_sequencer_if.sv
// rtl/reg_move_sequencer_if.sv - start/busy/done handshake and Ctrl_Bus select/load lines of the move sequencer
interface reg_move_sequencer_if;
    logic       start;
    logic [3:0] src;
    logic [3:0] dst;
    logic [7:0] sel;
    logic [9:0] ld;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, src, dst,
        input  sel, ld, busy, done, err
    );

    modport slave (
        input  start, src, dst,
        output sel, ld, busy, done, err
    );
endinterface

// File: rtl/reg_move_sequencer.sv
// rtl/reg_move_sequencer.sv - one MOV8 register-to-register move with settle/load/hold bracketing
module reg_move_sequencer #(
    parameter int SEL_SETUP = 2,
    parameter int LD_WIDTH  = 2,
    parameter int SEL_HOLD  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_move_sequencer_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] SETUP_M1 = 4'(SEL_SETUP - 1);
    localparam logic [3:0] LD_M1    = 4'(LD_WIDTH - 1);
    localparam logic [3:0] HOLD_M1  = 4'(SEL_HOLD - 1);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_src;
    logic [3:0] r_dst;
    logic       r_bad;
    logic [7:0] r_sel;
    logic [9:0] r_ld;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic [2:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_src_nxt;
    logic [3:0] w_dst_nxt;
    logic       w_bad_nxt;
    logic [7:0] w_sel_nxt;
    logic [9:0] w_ld_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic       w_drive_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_bad_nxt   = r_bad;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_src_nxt = bus.src;
                    w_dst_nxt = bus.dst;
                    w_bad_nxt = (bus.src > 4'd7) || (bus.dst > 4'd9);
                    if (w_bad_nxt) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = SETUP_M1;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = LD_M1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_LOAD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_M1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they register on the same edge the state moves;
    // an illegal request never enters SETUP/LOAD/HOLD, so no strobe sees an out-of-range code.
    always_comb begin
        w_drive_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_HOLD);
        w_sel_nxt   = w_drive_nxt ? (8'd1 << w_src_nxt[2:0]) : 8'd0;
        w_ld_nxt    = (w_state_nxt == ST_LOAD) ? (10'd1 << w_dst_nxt) : 10'd0;
        w_busy_nxt  = w_drive_nxt;
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_err_nxt   = w_done_nxt && w_bad_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_src   <= 4'd0;
            r_dst   <= 4'd0;
            r_bad   <= 1'b0;
            r_sel   <= 8'd0;
            r_ld    <= 10'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_bad   <= w_bad_nxt;
            r_sel   <= w_sel_nxt;
            r_ld    <= w_ld_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.sel  = r_sel;
    assign bus.ld   = r_ld;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_reg_move_sequencer.sv
// tb/tb_reg_move_sequencer.sv - scoreboard bench for reg_move_sequencer at two timing settings
module tb_reg_move_sequencer;
    typedef struct {
        int         acc;
        int         done_c;
        logic [3:0] s;
        logic [3:0] d;
        bit         legal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    int ps [2] = '{2, 3};
    int pl [2] = '{2, 1};
    int ph [2] = '{1, 2};
    int nidle [2] = '{0, 0};

    exp_t q0[$];
    exp_t q1[$];

    reg_move_sequencer_if ifa ();
    reg_move_sequencer_if ifb ();

    reg_move_sequencer #(.SEL_SETUP(2), .LD_WIDTH(2), .SEL_HOLD(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    reg_move_sequencer #(.SEL_SETUP(3), .LD_WIDTH(1), .SEL_HOLD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected {sel, ld, busy, done, err} for period c of move e, straight from the latency rules.
    function automatic logic [20:0] exp_vec(input exp_t e, input int s_su, input int s_ld,
                                            input int s_ho, input int c);
        logic [7:0] sel;
        logic [9:0] ld;
        logic       busy, dn, er;
        int         off;
        sel = 8'd0; ld = 10'd0; busy = 1'b0; dn = 1'b0; er = 1'b0;
        off = c - e.acc;
        if (e.legal) begin
            if (off >= 1 && off <= s_su + s_ld + s_ho) begin
                sel  = 8'd1 << e.s;
                busy = 1'b1;
            end
            if (off >= s_su + 1 && off <= s_su + s_ld) ld = 10'd1 << e.d;
            if (off == s_su + s_ld + s_ho + 1) dn = 1'b1;
        end else if (off == 1) begin
            dn = 1'b1;
            er = 1'b1;
        end
        return {sel, ld, busy, dn, er};
    endfunction

    always @(negedge clk) begin
        logic [20:0] ev, av;
        if (rst_n) begin
            ev = '0;
            if (q0.size() > 0) ev = exp_vec(q0[0], ps[0], pl[0], ph[0], cyc);
            av = {ifa.sel, ifa.ld, ifa.busy, ifa.done, ifa.err};
            n_chk++;
            if (av !== ev) begin
                n_fail++;
                $display("FAIL dut_a cyc=%0d actual=%h required=%h", cyc, av, ev);
            end
            if (q0.size() > 0 && cyc == q0[0].done_c) void'(q0.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [20:0] ev, av;
        if (rst_n) begin
            ev = '0;
            if (q1.size() > 0) ev = exp_vec(q1[0], ps[1], pl[1], ph[1], cyc);
            av = {ifb.sel, ifb.ld, ifb.busy, ifb.done, ifb.err};
            n_chk++;
            if (av !== ev) begin
                n_fail++;
                $display("FAIL dut_b cyc=%0d actual=%h required=%h", cyc, av, ev);
            end
            if (q1.size() > 0 && cyc == q1[0].done_c) void'(q1.pop_front());
        end
    end

    task automatic step(input bit st, input logic [3:0] s, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        ifa.start = st; ifa.src = s; ifa.dst = d;
        ifb.start = st; ifb.src = s; ifb.dst = d;
        if (st && rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (cyc >= nidle[k]) begin
                    e.acc    = cyc;
                    e.s      = s;
                    e.d      = d;
                    e.legal  = (s < 8) && (d < 10);
                    e.done_c = cyc + (e.legal ? ps[k] + pl[k] + ph[k] + 1 : 1);
                    nidle[k] = e.done_c + 1;
                    if (k == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 4'($urandom));
    endtask

    task automatic check_zero(input string name);
        logic [20:0] av;
        av = {ifa.sel, ifa.ld, ifa.busy, ifa.done, ifa.err};
        n_chk++;
        if (av !== 21'd0) begin
            n_fail++;
            $display("FAIL %s_a actual=%h required=0", name, av);
        end
        av = {ifb.sel, ifb.ld, ifb.busy, ifb.done, ifb.err};
        n_chk++;
        if (av !== 21'd0) begin
            n_fail++;
            $display("FAIL %s_b actual=%h required=0", name, av);
        end
    endtask

    task automatic pulse_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        q0.delete();
        q1.delete();
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        nidle[0] = cyc;
        nidle[1] = cyc;
    endtask

    initial begin
        logic [3:0] s, d;
        ifa.start = 1'b0; ifa.src = 4'd0; ifa.dst = 4'd0;
        ifb.start = 1'b0; ifb.src = 4'd0; ifb.dst = 4'd0;
        #1;
        check_zero("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nidle[0] = cyc;
        nidle[1] = cyc;

        step(1'b1, 4'd1, 4'd2);  idle(10);
        step(1'b1, 4'd0, 4'd9);  idle(10);
        step(1'b1, 4'd8, 4'd2);  idle(3);
        step(1'b1, 4'd1, 4'd12); idle(3);
        step(1'b1, 4'd3, 4'd3);  idle(10);
        step(1'b1, 4'd7, 4'd8);  idle(10);

        step(1'b1, 4'd1, 4'd2);
        step(1'b0, 4'd6, 4'd0);
        step(1'b1, 4'd5, 4'd6);
        step(1'b0, 4'd4, 4'd1);
        step(1'b1, 4'd7, 4'd0);
        idle(10);

        for (int i = 0; i < 20; i++) step(1'b1, 4'd2, 4'd5);
        idle(10);

        step(1'b1, 4'd1, 4'd2);
        idle(2);
        pulse_reset(2);
        step(1'b1, 4'd6, 4'd4);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            s = ($urandom % 8 == 0) ? 4'(8 + $urandom % 8) : 4'($urandom % 8);
            d = ($urandom % 8 == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
            step(($urandom % 3) == 0, s, d);
            if (i == 200) pulse_reset(1);
        end
        idle(20);

        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d/%0d pending required=0/0", q0.size(), q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
